// File: rtl/imem_pkg.sv
// Shared types and helpers for the loadable instruction memory.
// Optional byte parity is enabled by defining IMEM_PARITY_EN.
package imem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } imem_state_e;

    localparam int          WORD_BYTES  = 4;
    localparam logic [31:0] FAULT_INSTR = 32'h0000_0000;

    // Even-parity bit for one byte: the stored bit makes the 9-bit total even.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

    // Parity of the four bytes of a word; bit 3 belongs to the lowest address.
    function automatic logic [3:0] word_parity(input logic [31:0] w);
        logic [3:0] p;
        p[3] = byte_parity(w[31:24]);
        p[2] = byte_parity(w[23:16]);
        p[1] = byte_parity(w[15:8]);
        p[0] = byte_parity(w[7:0]);
        return p;
    endfunction

endpackage

// File: rtl/imem_load_ctrl.sv
// Load-port controller: IDLE/LOAD/RUN FSM, byte write pointer, ld_ready and
// sticky load_full, plus the write strobe/address used by the memory array.
module imem_load_ctrl
    import imem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int PTR_W       = $clog2(DEPTH_BYTES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_start,
    input  logic             ld_valid,
    input  logic             ld_last,
    output logic             ld_ready,
    output logic             load_full,
    output logic             wr_en,
    output logic [PTR_W-1:0] wr_addr,
    output logic [1:0]       state_o
);

    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH_BYTES - WORD_BYTES);
    localparam logic [PTR_W-1:0] PTR_STEP  = PTR_W'(WORD_BYTES);

    imem_state_e      state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             full_q, full_d;
    logic             ready_q, ready_d;
    logic             wr_en_s;

    // Next-state logic for the FSM, load pointer and status flags.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        full_d  = full_q;
        wr_en_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ld_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    full_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (ld_start) begin
                    // Restart of an in-progress load; the word on ld_data is not stored.
                    ptr_d  = '0;
                    full_d = 1'b0;
                end else if (ld_valid) begin
                    wr_en_s = 1'b1;
                    ptr_d   = ptr_q + PTR_STEP;
                    if (ptr_q == LAST_SLOT) begin
                        full_d  = 1'b1;
                        state_d = ST_RUN;
                    end else if (ld_last) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (ld_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    full_d  = 1'b0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
                full_d  = 1'b0;
            end
        endcase
        ready_d = (state_d == ST_LOAD);
    end

    // Control state register; synchronous reset leaves the memory untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            full_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            full_q  <= full_d;
            ready_q <= ready_d;
        end
    end

    assign ld_ready  = ready_q;
    assign load_full = full_q;
    assign wr_en     = wr_en_s;
    assign wr_addr   = ptr_q;
    assign state_o   = state_q;

endmodule

// File: rtl/imem_loadable.sv
// Byte-addressed, big-endian instruction memory with a sequential load port
// and a one-cycle registered fetch port (stall/flush, fault detection).
// Define IMEM_PARITY_EN to store and check one even-parity bit per byte.
module imem_loadable
    import imem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_BYTES = 1024,
    parameter int INSTR_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld_start,
    input  logic               ld_valid,
    input  logic [INSTR_W-1:0] ld_data,
    input  logic               ld_last,
    output logic               ld_ready,
    output logic               load_full,
    input  logic               fetch_en,
    input  logic [ADDR_W-1:0]  fetch_addr,
    input  logic               stall,
    input  logic               flush,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic               addr_fault,
    output logic               parity_err,
    output logic [1:0]         state_o
);

    localparam int              PTR_W    = $clog2(DEPTH_BYTES);
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DEPTH_BYTES - WORD_BYTES);

    // Memory contents are deliberately outside the reset domain.
    logic [7:0]         mem_q [DEPTH_BYTES];

    logic               wr_en_s;
    logic [PTR_W-1:0]   wr_addr_s;
    logic [1:0]         state_s;

    logic [PTR_W-1:0]   rd_idx_s;
    logic [INSTR_W-1:0] rd_word_s;
    logic               fault_s;
    logic               perr_s;

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               fault_q, fault_d;
    logic               perr_q, perr_d;

    imem_load_ctrl #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .PTR_W       (PTR_W)
    ) u_load_ctrl (
        .clk       (clk),
        .rst       (rst),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .load_full (load_full),
        .wr_en     (wr_en_s),
        .wr_addr   (wr_addr_s),
        .state_o   (state_s)
    );

    // Big-endian word write: ld_data[31:24] lands at the lowest byte address.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int k = 0; k < WORD_BYTES; k++) begin
                mem_q[wr_addr_s + PTR_W'(k)] <= ld_data[INSTR_W-1-8*k -: 8];
            end
        end else begin
            for (int k = 0; k < WORD_BYTES; k++) begin
                mem_q[wr_addr_s + PTR_W'(k)] <= mem_q[wr_addr_s + PTR_W'(k)];
            end
        end
    end

    // Misaligned or beyond the last full word; no wrap-around into low memory.
    always_comb begin
        fault_s  = (fetch_addr[1:0] != 2'b00) || (fetch_addr > MAX_ADDR);
        rd_idx_s = fetch_addr[PTR_W-1:0];
    end

    // Assemble the addressed word from four consecutive bytes (old contents on a same-cycle write).
    always_comb begin
        rd_word_s = '0;
        for (int k = 0; k < WORD_BYTES; k++) begin
            rd_word_s[INSTR_W-1-8*k -: 8] = mem_q[rd_idx_s + PTR_W'(k)];
        end
    end

`ifdef IMEM_PARITY_EN
    logic       par_q [DEPTH_BYTES];
    logic [3:0] rd_par_s;

    // Parity bits are written alongside the data bytes and, like them, survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int k = 0; k < WORD_BYTES; k++) begin
                par_q[wr_addr_s + PTR_W'(k)] <= byte_parity(ld_data[INSTR_W-1-8*k -: 8]);
            end
        end else begin
            for (int k = 0; k < WORD_BYTES; k++) begin
                par_q[wr_addr_s + PTR_W'(k)] <= par_q[wr_addr_s + PTR_W'(k)];
            end
        end
    end

    // Recompute parity on the fetched bytes and flag any disagreement.
    always_comb begin
        rd_par_s = 4'b0000;
        for (int k = 0; k < WORD_BYTES; k++) begin
            rd_par_s[3-k] = par_q[rd_idx_s + PTR_W'(k)];
        end
        perr_s = |(word_parity(rd_word_s) ^ rd_par_s);
    end
`else
    // Without parity storage the error flag can never be raised.
    always_comb begin
        perr_s = 1'b0;
    end
`endif

    // Fetch pipeline next state; priority flush > stall > fetch_en.
    always_comb begin
        instr_d = instr_q;
        valid_d = valid_q;
        fault_d = fault_q;
        perr_d  = perr_q;
        if (flush) begin
            instr_d = FAULT_INSTR;
            valid_d = 1'b0;
            fault_d = 1'b0;
            perr_d  = 1'b0;
        end else if (stall) begin
            instr_d = instr_q;
        end else if (fetch_en && (state_s != ST_LOAD)) begin
            valid_d = 1'b1;
            if (fault_s) begin
                instr_d = FAULT_INSTR;
                fault_d = 1'b1;
                perr_d  = 1'b0;
            end else begin
                instr_d = rd_word_s;
                fault_d = 1'b0;
                perr_d  = perr_s;
            end
        end else begin
            instr_d = FAULT_INSTR;
            valid_d = 1'b0;
            fault_d = 1'b0;
            perr_d  = 1'b0;
        end
    end

    // Fetch output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            instr_q <= instr_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            perr_q  <= perr_d;
        end
    end

    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign addr_fault  = fault_q;
    assign parity_err  = perr_q;
    assign state_o     = state_s;

endmodule

// File: tb/tb_imem_loadable.sv
// Self-checking bench: two instances (1024-byte and 16-byte) share stimulus;
// a behavioural model pushes expected outputs per cycle, compared after the edge.
module tb_imem_loadable;

    logic        clk = 1'b0;
    logic        rst, ld_start, ld_valid, ld_last, fetch_en, stall, flush;
    logic [31:0] ld_data, fetch_addr;

    logic        a_ready, a_full, a_valid, a_fault, a_perr;
    logic [31:0] a_instr;
    logic [1:0]  a_state;
    logic        b_ready, b_full, b_valid, b_fault, b_perr;
    logic [31:0] b_instr;
    logic [1:0]  b_state;

    always #5 clk = ~clk;

    imem_loadable #(.ADDR_W(32), .DEPTH_BYTES(1024), .INSTR_W(32)) u_dut (
        .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_last(ld_last), .ld_ready(a_ready), .load_full(a_full),
        .fetch_en(fetch_en), .fetch_addr(fetch_addr), .stall(stall), .flush(flush),
        .instr(a_instr), .instr_valid(a_valid), .addr_fault(a_fault),
        .parity_err(a_perr), .state_o(a_state)
    );

    imem_loadable #(.ADDR_W(32), .DEPTH_BYTES(16), .INSTR_W(32)) u_dut16 (
        .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_last(ld_last), .ld_ready(b_ready), .load_full(b_full),
        .fetch_en(fetch_en), .fetch_addr(fetch_addr), .stall(stall), .flush(flush),
        .instr(b_instr), .instr_valid(b_valid), .addr_fault(b_fault),
        .parity_err(b_perr), .state_o(b_state)
    );

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        fault;
        logic        perr;
        logic        ready;
        logic        full;
        logic [1:0]  st;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Model state for instance 0 (1024 bytes) and instance 1 (16 bytes).
    logic [7:0]  m_mem [2][1024];
    logic        m_bad [2][1024];
    int          m_depth [2];
    logic [1:0]  m_st [2];
    int          m_ptr [2];
    logic        m_full [2];
    logic [31:0] m_instr [2];
    logic        m_valid [2];
    logic        m_fault [2];
    logic        m_perr [2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_idle();
        rst = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        ld_data = 32'h0; fetch_en = 1'b0; fetch_addr = 32'h0; stall = 1'b0; flush = 1'b0;
    endtask

    // Advance the model one cycle for instance i and queue the expected outputs.
    task automatic model_cycle(input int i);
        exp_t        e;
        logic [1:0]  s;
        int          a;
        s = m_st[i];
        if (rst) begin
            m_instr[i] = 32'h0; m_valid[i] = 1'b0; m_fault[i] = 1'b0; m_perr[i] = 1'b0;
        end else if (flush) begin
            m_instr[i] = 32'h0; m_valid[i] = 1'b0; m_fault[i] = 1'b0; m_perr[i] = 1'b0;
        end else if (stall) begin
            m_valid[i] = m_valid[i];
        end else if (fetch_en && s != 2'd1) begin
            m_valid[i] = 1'b1;
            if (fetch_addr[1:0] != 2'b00 || fetch_addr > 32'(m_depth[i] - 4)) begin
                m_instr[i] = 32'h0; m_fault[i] = 1'b1; m_perr[i] = 1'b0;
            end else begin
                a = int'(fetch_addr);
                m_instr[i] = {m_mem[i][a], m_mem[i][a+1], m_mem[i][a+2], m_mem[i][a+3]};
                m_fault[i] = 1'b0;
                m_perr[i]  = m_bad[i][a] | m_bad[i][a+1] | m_bad[i][a+2] | m_bad[i][a+3];
            end
        end else begin
            m_instr[i] = 32'h0; m_valid[i] = 1'b0; m_fault[i] = 1'b0; m_perr[i] = 1'b0;
        end
        if (rst) begin
            m_st[i] = 2'd0; m_ptr[i] = 0; m_full[i] = 1'b0;
        end else if (ld_start && (s == 2'd0 || s == 2'd1 || s == 2'd2)) begin
            m_st[i] = 2'd1; m_ptr[i] = 0; m_full[i] = 1'b0;
        end else if (s == 2'd1 && ld_valid) begin
            for (int k = 0; k < 4; k++) begin
                m_mem[i][m_ptr[i] + k] = ld_data[31-8*k -: 8];
                m_bad[i][m_ptr[i] + k] = 1'b0;
            end
            if (m_ptr[i] == m_depth[i] - 4) begin
                m_full[i] = 1'b1; m_st[i] = 2'd2;
            end else if (ld_last) begin
                m_st[i] = 2'd2;
            end
            m_ptr[i] = (m_ptr[i] + 4) % m_depth[i];
        end
        e.instr = m_instr[i]; e.valid = m_valid[i]; e.fault = m_fault[i];
        e.perr  = m_perr[i];  e.ready = (m_st[i] == 2'd1); e.full = m_full[i];
        e.st    = m_st[i];
        sb_q.push_back(e);
    endtask

    task automatic compare_inst(input string nm, input exp_t e, input logic [31:0] instr_o,
                                input logic valid_o, input logic fault_o, input logic perr_o,
                                input logic ready_o, input logic full_o, input logic [1:0] st_o);
        check_val({nm, ".instr_valid"}, 32'(valid_o), 32'(e.valid));
        if (e.valid) check_val({nm, ".instr"}, instr_o, e.instr);
        check_val({nm, ".addr_fault"}, 32'(fault_o), 32'(e.fault));
        check_val({nm, ".parity_err"}, 32'(perr_o), 32'(e.perr));
        check_val({nm, ".ld_ready"}, 32'(ready_o), 32'(e.ready));
        check_val({nm, ".load_full"}, 32'(full_o), 32'(e.full));
        check_val({nm, ".state"}, 32'(st_o), 32'(e.st));
    endtask

    // One clock: queue expectations from current inputs, clock, then check both DUTs.
    task automatic step();
        exp_t e;
        model_cycle(0);
        model_cycle(1);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        compare_inst("d1024", e, a_instr, a_valid, a_fault, a_perr, a_ready, a_full, a_state);
        e = sb_q.pop_front();
        compare_inst("d16", e, b_instr, b_valid, b_fault, b_perr, b_ready, b_full, b_state);
    endtask

    task automatic fetch(input logic [31:0] addr);
        fetch_en = 1'b1; fetch_addr = addr;
        step();
        fetch_en = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] w, input logic last);
        ld_valid = 1'b1; ld_data = w; ld_last = last;
        step();
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    logic [31:0] prog [3];

    initial begin
        prog[0] = 32'hE3A0_0014; prog[1] = 32'hE3A0_1A01; prog[2] = 32'hE3A0_2103;
        m_depth[0] = 1024; m_depth[1] = 16;
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 2'd0; m_ptr[i] = 0; m_full[i] = 1'b0;
            m_instr[i] = 32'h0; m_valid[i] = 1'b0; m_fault[i] = 1'b0; m_perr[i] = 1'b0;
            for (int j = 0; j < 1024; j++) begin
                m_mem[i][j] = 8'h00; m_bad[i][j] = 1'b0;
            end
        end

        set_idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Basic load of three words, ld_last on the third.
        ld_start = 1'b1; step(); ld_start = 1'b0;
        for (int k = 0; k < 3; k++) load_word(prog[k], (k == 2));
        fetch(32'h4);

        // Stall holds the previous result while the address changes.
        fetch(32'h0);
        fetch_en = 1'b1; fetch_addr = 32'h8; stall = 1'b1;
        for (int k = 0; k < 3; k++) step();
        stall = 1'b0;
        step();
        fetch_en = 1'b0;

        // Faults: misaligned and just past the end.
        fetch(32'h6);
        fetch(32'h400);
        fetch(32'h3FC);

        // Flush beats a same-cycle fetch.
        flush = 1'b1; fetch(32'h0); flush = 1'b0;
        fetch(32'h0);
        step();

        // Reset in the middle of a load keeps already written words.
        ld_start = 1'b1; step(); ld_start = 1'b0;
        load_word(prog[0], 1'b0);
        load_word(prog[1], 1'b0);
        rst = 1'b1; step(); rst = 1'b0;
        fetch(32'h4);
        fetch(32'h0);

        // Fill the 16-byte instance without ld_last; the fifth word is dropped.
        ld_start = 1'b1; step(); ld_start = 1'b0;
        for (int k = 0; k < 5; k++) load_word(32'hA000_0001 + 32'(k) * 32'h0101_0101, 1'b0);
        fetch(32'h0);
        fetch(32'hC);
        fetch(32'h10);

`ifdef IMEM_PARITY_EN
        u_dut16.mem_q[1] = u_dut16.mem_q[1] ^ 8'h01;
        m_mem[1][1] = m_mem[1][1] ^ 8'h01;
        m_bad[1][1] = 1'b1;
        fetch(32'h0);
        fetch(32'h4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised, byte-addressed, big-endian instruction memory for the ARM core's IF stage.
- Replaces the hard-wired boot program with a sequential load port driven by the testbench or boot loader.
- Provides a registered fetch port with stall and flush.
- Memory contents survive reset; only control state is cleared.

Parameters:
ADDR_W, 32, fetch address width (byte address)
DEPTH_BYTES, 1024, memory size in bytes; power of two, multiple of 4
INSTR_W, 32, instruction width; fixed at 4 bytes (WORD_BYTES=4)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; synchronous, active-high
ld_start  in  1  enter LOAD state, pointer cleared to 0
ld_valid  in  1  ld_data valid this cycle
ld_data  in  32  instruction word; [31:24] stored at lowest byte address
ld_last  in  1  qualifies final word of load
ld_ready  out  1  high only in LOAD
load_full  out  1  sticky: last slot written during current load
fetch_en  in  1  fetch request
fetch_addr  in  ADDR_W  byte address
stall  in  1  hold fetch output
flush  in  1  invalidate fetch output
instr  out  32  fetched instruction
instr_valid  out  1  instr valid
addr_fault  out  1  misaligned or out-of-range fetch
parity_err  out  1  see Optional Feature
state_o  out  2  IDLE=0, LOAD=1, RUN=2

Behaviour:
- Reset values:
  - state IDLE, ld_ptr 0, ld_ready 0, load_full 0.
  - instr 0, instr_valid 0, addr_fault 0, parity_err 0.
  - Memory array is not modified by reset.
- FSM transitions:
  - IDLE -ld_start-> LOAD.
  - LOAD -(ld_valid & (ld_last | ld_ptr==DEPTH_BYTES-4))-> RUN.
  - RUN -ld_start-> LOAD.
  - ld_start in LOAD restarts the pointer at 0 and clears load_full.
- LOAD:
  - Each ld_valid writes 4 bytes at ld_ptr..ld_ptr+3 (big-endian), then ld_ptr += 4.
  - A write to slot DEPTH_BYTES-4 sets load_full and exits to RUN.
  - ld_valid outside LOAD is ignored.
- Fetch (IDLE and RUN only; in LOAD fetch_en is ignored and instr_valid=0 next cycle):
  - One-cycle latency: fetch_en & ~stall at edge N → instr and instr_valid=1 updated at edge N+1.
  - Read-after-load to the same address in the same cycle returns the old contents.
  - Priority: rst > flush > stall > fetch_en.
  - flush: instr_valid=0 next cycle; instr is don't-care (drive 0).
  - stall: instr, instr_valid, addr_fault and parity_err hold.
  - fetch_en=0 without stall: instr_valid=0 next cycle.
- Faults:
  - fetch_addr[1:0]!=0 or fetch_addr>DEPTH_BYTES-4 → instr=0, instr_valid=1, addr_fault=1.
  - No memory read is performed on a faulting fetch.
  - Wrap-around is not permitted.
- Reset mid-load → IDLE; words already written remain fetchable.

Optional Feature:
- Macro: IMEM_PARITY_EN.
- Defined:
  - Each byte stores one extra even-parity bit computed on load.
  - Fetch recomputes parity; parity_err=1 (aligned with instr_valid) if any of the 4 bytes mismatch.
  - The instruction is still returned.
- Undefined: no parity storage; parity_err tied 0.

Decomposition:
- Package imem_pkg:
  - state enum (IDLE/LOAD/RUN)
  - WORD_BYTES=4
  - FAULT_INSTR=32'h0
  - byte-parity function
- Sub-module imem_load_ctrl: FSM, ld_ptr, ld_ready/load_full, write-enable generation.
- Top holds the array and the fetch pipeline register.

Test Plan:
- Load 0xE3A00014, 0xE3A01A01, 0xE3A02103 (ld_last on third) → state RUN; fetch 0x4 → next cycle instr=0xE3A01A01, instr_valid=1.
- Fetch 0x0, then assert stall while fetch_addr=0x8 for 3 cycles → instr stays 0xE3A00014; release → 0xE3A02103.
- Fetch 0x6 → addr_fault=1, instr=0. Fetch 0x400 (DEPTH_BYTES=1024) → addr_fault=1.
- flush and fetch_en same cycle → instr_valid=0; next fetch 0x0 → valid 0xE3A00014.
- Reset after 2 load words → state IDLE, ld_ready=0; fetch 0x4 → 0xE3A01A01 retained.
- DEPTH_BYTES=16, load 5 words without ld_last → load_full=1 after 4th, state RUN, 5th dropped; with IMEM_PARITY_EN, backdoor-flip a bit of byte 0x1 → fetch 0x0 gives parity_err=1.
